debug_sequencer: RTL

//  Byte-command sequencer between UART rx/tx and the accumulator CPU (control_top + datapath).

---
 rtl/debug_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/debug_sequencer.sv
// Byte-command sequencer between the UART and the accumulator CPU: loads program memory, runs or single-steps the CPU, then reports PC/ACC/cycle count.
// CPU enable/reset and tx strobes are registered; program writes are issued in the LD_LO byte cycle; transmit is paced by i_tx_done and commands are not accepted while busy.
module debug_sequencer #(
  parameter int         BITS     = 16,
  parameter int         DTBITS   = 11,
  parameter logic [7:0] CMD_LOAD = 8'h4C,
  parameter logic [7:0] CMD_RUN  = 8'h52,
  parameter logic [7:0] CMD_STEP = 8'h53
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_done,
  output logic              o_prog_we,
  output logic [DTBITS-1:0] o_prog_addr,
  output logic [BITS-1:0]   o_prog_data,
  output logic              o_cpu_en,
  output logic              o_cpu_rst,
  input  logic              i_halt,
  input  logic [DTBITS-1:0] i_pc,
  input  logic [BITS-1:0]   i_acc,
  output logic              o_busy
);

  localparam int SNAPW = 3 * BITS;

  typedef enum logic [2:0] {
    IDLE, LD_LEN, LD_HI, LD_LO, RUN, STEP, REPORT, TX_WAIT
  } state_t;

  state_t            state, nxt_state;
  logic [DTBITS-1:0] ptr, nxt_ptr;
  logic [7:0]        words_left, nxt_words_left;
  logic [7:0]        hi_byte, nxt_hi_byte;
  logic [BITS-1:0]   cyc, nxt_cyc;
  logic              step_done, nxt_step_done;
  logic [2:0]        byte_idx, nxt_byte_idx;
  logic [SNAPW-1:0]  snap, nxt_snap, live;
  logic              cpu_en, nxt_cpu_en;
  logic              cpu_rst, nxt_cpu_rst;
  logic              tx_start, nxt_tx_start;
  logic [7:0]        tx_data, nxt_tx_data;
  logic              prog_we;

  assign live = {{(BITS-DTBITS){1'b0}}, i_pc, i_acc, cyc};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state      <= IDLE;
      ptr        <= '0;
      words_left <= '0;
      hi_byte    <= '0;
      cyc        <= '0;
      step_done  <= 1'b0;
      byte_idx   <= '0;
      snap       <= '0;
      cpu_en     <= 1'b0;
      cpu_rst    <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
    end else begin
      state      <= nxt_state;
      ptr        <= nxt_ptr;
      words_left <= nxt_words_left;
      hi_byte    <= nxt_hi_byte;
      cyc        <= nxt_cyc;
      step_done  <= nxt_step_done;
      byte_idx   <= nxt_byte_idx;
      snap       <= nxt_snap;
      cpu_en     <= nxt_cpu_en;
      cpu_rst    <= nxt_cpu_rst;
      tx_start   <= nxt_tx_start;
      tx_data    <= nxt_tx_data;
    end
  end

  always_comb begin
    nxt_state      = state;
    nxt_ptr        = ptr;
    nxt_words_left = words_left;
    nxt_hi_byte    = hi_byte;
    nxt_step_done  = step_done;
    nxt_byte_idx   = byte_idx;
    nxt_snap       = snap;
    nxt_cpu_en     = 1'b0;
    nxt_cpu_rst    = 1'b0;
    nxt_tx_start   = 1'b0;
    nxt_tx_data    = tx_data;
    prog_we        = 1'b0;
    // The count reflects enables already issued, so it is final by the first REPORT cycle.
    nxt_cyc        = (cpu_en && (cyc != '1)) ? cyc + BITS'(1) : cyc;

    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            nxt_state = LD_LEN;
          end else if (i_rx_data == CMD_RUN) begin
            nxt_state = RUN;
          end else if (i_rx_data == CMD_STEP) begin
            nxt_state     = STEP;
            nxt_step_done = 1'b0;
          end
        end
      end
      LD_LEN: begin
        if (i_rx_valid) begin
          if (i_rx_data == 8'd0) begin
            nxt_state = IDLE;
          end else begin
            nxt_words_left = i_rx_data;
            nxt_ptr        = '0;
            nxt_state      = LD_HI;
          end
        end
      end
      LD_HI: begin
        if (i_rx_valid) begin
          nxt_hi_byte = i_rx_data;
          nxt_state   = LD_LO;
        end
      end
      LD_LO: begin
        if (i_rx_valid) begin
          prog_we = 1'b1;
          nxt_ptr = ptr + DTBITS'(1);
          if (words_left == 8'd1) begin
            nxt_cpu_rst = 1'b1;
            nxt_cyc     = '0;
            nxt_state   = IDLE;
          end else begin
            nxt_words_left = words_left - 8'd1;
            nxt_state      = LD_HI;
          end
        end
      end
      RUN: begin
        if (i_halt || i_rx_valid) begin
          nxt_byte_idx = '0;
          nxt_state    = REPORT;
        end else begin
          nxt_cpu_en = 1'b1;
        end
      end
      STEP: begin
        // First cycle issues the single enable; second lets it land in the count.
        if (!step_done) begin
          nxt_cpu_en    = !i_halt;
          nxt_step_done = 1'b1;
        end else begin
          nxt_step_done = 1'b0;
          nxt_byte_idx  = '0;
          nxt_state     = REPORT;
        end
      end
      REPORT: begin
        if (byte_idx == 3'd0) begin
          nxt_tx_data = live[SNAPW-1 -: 8];
          nxt_snap    = live << 8;
        end else begin
          nxt_tx_data = snap[SNAPW-1 -: 8];
          nxt_snap    = snap << 8;
        end
        nxt_tx_start = 1'b1;
        nxt_state    = TX_WAIT;
      end
      TX_WAIT: begin
        if (i_tx_done && !tx_start) begin
          if (byte_idx == 3'd5) begin
            nxt_state = IDLE;
          end else begin
            nxt_byte_idx = byte_idx + 3'd1;
            nxt_state    = REPORT;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign o_prog_we   = prog_we;
  assign o_prog_addr = prog_we ? ptr : '0;
  assign o_prog_data = prog_we ? BITS'({hi_byte, i_rx_data}) : '0;
  assign o_cpu_en    = cpu_en;
  assign o_cpu_rst   = cpu_rst;
  assign o_tx_start  = tx_start;
  assign o_tx_data   = tx_data;
  assign o_busy      = (state != IDLE);

endmodule
